out_wrapper_fifo: RTL and testbench

//  Output wrapper directly downstream of Mdatapath. It captures each result word Mdatapath

---
 rtl/out_wrapper_fifo_pkg.sv | 14 +
 rtl/out_wrapper_fifo_ram.sv | 35 +++
 rtl/out_wrapper_fifo.sv | 96 +++++++++
 tb/tb_out_wrapper_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/out_wrapper_fifo_pkg.sv
// Shared defaults for the output wrapper FIFO: data/depth parameters and the
// batch FSM state encodings.
package out_wrapper_fifo_pkg;

  localparam int DEF_DATA_W = 21;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/out_wrapper_fifo_ram.sv
// DEPTH x DATA_W register array with a synchronous write port and a registered
// read port whose output register holds its value between reads.
module out_wrapper_fifo_ram #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the storage array has no reset; stale words are unreachable once the
  // pointers and count are cleared, so only the read register needs one.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/out_wrapper_fifo.sv
// Output wrapper behind Mdatapath: circular FIFO with back-pressure, sticky
// overflow, registered read port and a batch tracker that pulses batch_done.
module out_wrapper_fifo
  import out_wrapper_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wDone,
  output logic              full,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              batch_done
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, overflow_q;
  logic [1:0]        state_q, state_d;
  logic              wr_acc, rd_acc;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign wr_acc = wr_req && !full;
  assign rd_acc = rd_req && !empty;

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
  end

  // wDone wins over a same-cycle write in IDLE: that write still joins the batch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (wDone) state_d = ST_FLUSH;
                  else if (wr_acc) state_d = ST_COLLECT;
      ST_COLLECT: if (wDone) state_d = ST_FLUSH;
      ST_FLUSH:   if (count_d == '0) state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + 1'b1;
      if (rd_acc) rptr_q <= rptr_q + 1'b1;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      overflow_q <= overflow_q | (wr_req && full);
      state_q    <= state_d;
    end
  end

  out_wrapper_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  assign count      = count_q;
  assign rd_valid   = rd_valid_q;
  assign overflow   = overflow_q;
  assign batch_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_out_wrapper_fifo.sv
// Self-checking bench for out_wrapper_fifo: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_out_wrapper_fifo;

  logic        clk = 1'b0;
  logic        rst, wr_req, wDone, rd_req;
  logic [20:0] wr_data;
  logic        full, empty, rd_valid, overflow, batch_done;
  logic [20:0] rd_data;
  logic [3:0]  count;

  out_wrapper_fifo dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wDone(wDone),
    .full(full), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .count(count), .overflow(overflow), .batch_done(batch_done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: a queue of stored words plus a batch phase tracker.
  logic [20:0] mq[$];
  logic [20:0] m_data;
  logic        m_valid, m_ovf;
  int          m_phase;  // 0 idle, 1 collecting, 2 draining, 3 done pulse

  typedef struct {
    logic        r, w;
    logic [20:0] wd;
    logic        rd, dn;
    logic [3:0]  c;
    logic        f, e, v;
    logic [20:0] d;
    logic        o, b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic w, logic [20:0] wd, logic rd, logic dn,
                              logic [3:0] c, logic f, logic e, logic v,
                              logic [20:0] d, logic o, logic b);
    vec_t t;
    t.r = r; t.w = w; t.wd = wd; t.rd = rd; t.dn = dn;
    t.c = c; t.f = f; t.e = e; t.v = v; t.d = d; t.o = o; t.b = b;
    return t;
  endfunction

  function automatic logic [31:0] pack(logic [3:0] c, logic f, logic e, logic v,
                                       logic o, logic b, logic [20:0] d);
    return {2'b00, c, f, e, v, o, b, d};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(count, full, empty, rd_valid, overflow, batch_done, rd_data);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_update(input logic r, input logic w, input logic [20:0] d,
                              input logic rd, input logic dn);
    logic was_full, was_empty, wa, ra;
    if (r) begin
      mq.delete();
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_phase = 0;
      return;
    end
    was_full  = (mq.size() == 8);
    was_empty = (mq.size() == 0);
    wa = w && !was_full;
    ra = rd && !was_empty;
    m_valid = ra;
    if (ra) m_data = mq.pop_front();
    if (wa) mq.push_back(d);
    if (w && was_full) m_ovf = 1'b1;
    case (m_phase)
      0:       if (dn) m_phase = 2; else if (wa) m_phase = 1;
      1:       if (dn) m_phase = 2;
      2:       if (mq.size() == 0) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [31:0] model_vec();
    return pack(4'(mq.size()), mq.size() == 8, mq.size() == 0, m_valid, m_ovf,
                m_phase == 3, m_data);
  endfunction

  // One clock: drive, let the edge pass, sample 1 time unit later, check model.
  task automatic step(input logic r, input logic w, input logic [20:0] d,
                      input logic rd, input logic dn);
    rst = r; wr_req = w; wr_data = d; rd_req = rd; wDone = dn;
    @(posedge clk);
    #1;
    model_update(r, w, d, rd, dn);
    check("model", dut_vec(), model_vec());
  endtask

  initial begin
    int bd_pulses, got;
    logic [20:0] exp_words[6];
    rst = 1'b1; wr_req = 1'b0; wr_data = '0; rd_req = 1'b0; wDone = 1'b0;

    // Reset/idle, three-word write/read, empty batch, two-word batch.
    tbl.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,2,0,0, 2,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,3,0,0, 3,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 2,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,0,0,1,2,0,0));
    tbl.push_back(mk(0,0,0,1,0, 0,0,1,1,3,0,0));
    tbl.push_back(mk(0,0,0,1,0, 0,0,1,0,3,0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1,0,3,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,3,0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,3,0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,1,5,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,6,0,1, 2,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,0,0,1,5,0,0));
    tbl.push_back(mk(0,0,0,1,0, 0,0,1,1,6,0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,6,0,0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].w, tbl[i].wd, tbl[i].rd, tbl[i].dn);
      check($sformatf("tbl[%0d]", i), dut_vec(),
            pack(tbl[i].c, tbl[i].f, tbl[i].e, tbl[i].v, tbl[i].o, tbl[i].b, tbl[i].d));
    end

    // Overfill: 9 writes, 9th dropped with sticky overflow, then drain 8.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 21'h10 + 21'(i), 0, 0);
      if (i == 7) check("full_after_8", {30'd0, full, overflow}, {30'd0, 2'b10});
    end
    check("ovf_after_9", {28'd0, count}, {28'd0, 4'd8});
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0);
      check($sformatf("drain[%0d]", i), {10'd0, rd_valid, rd_data}, {10'd0, 1'b1, 21'h10 + 21'(i)});
    end

    // Full with both strobes: read only, write dropped; empty with both: write only.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 21'h20 + 21'(i), 0, 0);
    step(0, 1, 21'h30, 1, 0);
    check("full_rw", dut_vec(), pack(4'd7, 0, 0, 1, 1, 0, 21'h20));
    for (int i = 1; i < 8; i++) step(0, 0, 0, 1, 0);
    check("drained_last", {11'd0, rd_data}, {11'd0, 21'h27});
    step(0, 1, 21'h31, 1, 0);
    check("empty_rw", dut_vec(), pack(4'd1, 0, 0, 0, 1, 0, 21'h27));
    step(0, 0, 0, 1, 0);
    check("empty_rw_word", {10'd0, rd_valid, rd_data}, {10'd0, 1'b1, 21'h31});

    // Reset mid-stream, then a datapath-style batch (vi=16'h0200, ui=2'b00).
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 21'h40 + 21'(i), 0, 0);
    step(1, 1, 21'h44, 0, 0);
    check("mid_rst", dut_vec(), pack(4'd0, 0, 1, 0, 0, 0, 21'h0));
    foreach (exp_words[i]) exp_words[i] = {3'b000, 16'h0200 + 16'(i * 3), 2'b00};
    bd_pulses = 0; got = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, exp_words[i], i > 1, i == 5);
      if (rd_valid) begin
        check($sformatf("batch_word[%0d]", got), {11'd0, rd_data}, {11'd0, exp_words[got]});
        got++;
      end
      if (batch_done) bd_pulses++;
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(0, 0, 0, 1, 0);
      if (rd_valid && got < 6) begin
        check($sformatf("batch_word[%0d]", got), {11'd0, rd_data}, {11'd0, exp_words[got]});
        got++;
      end
      if (batch_done) bd_pulses++;
    end
    check("batch_words_seen", 32'(got), 32'd6);
    check("batch_done_pulses", 32'(bd_pulses), 32'd1);

    // Randomized traffic against the reference model.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) == 0, $urandom_range(9) < 6, 21'($urandom),
           $urandom_range(1) == 1, $urandom_range(19) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
